// File: rtl/tcdm_bank_responder.sv
// tcdm_bank_responder
//
// Far-end model of one TCDM port. Accepts id-tagged read/write requests,
// services them from a local word array, and returns id-tagged responses
// in acceptance order after a fixed latency. Optional pseudo-random
// request backpressure is driven by a free-running 16-bit LFSR.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Once valid is raised, the payload is held until the transfer. Ready on
// the request side never depends on req_valid_i. The response payload is
// held stable while resp_valid_o && !resp_ready_i.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i/ready_o  request handshake
//   req_addr_i           byte address (word index taken above the byte offset)
//   req_wen_i            1 = write
//   req_wdata_i/be_i     write data and byte enables
//   req_id_i             request id, echoed on the response
//   resp_valid_i/ready_i response handshake
//   resp_rdata_o         read data (0 for write responses)
//   resp_id_o            echoed id
//   resp_write_o         1 if the response belongs to a write
//   stall_en_i           enables pseudo-random request backpressure
module tcdm_bank_responder #(
  parameter int unsigned NumWords  = 256,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdWidth   = 10,
  parameter int unsigned Latency   = 2,
  parameter int unsigned FifoDepth = 4,
  parameter logic [15:0] Seed      = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   req_wen_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  input  logic [IdWidth-1:0]     req_id_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [DataWidth-1:0]   resp_rdata_o,
  output logic [IdWidth-1:0]     resp_id_o,
  output logic                   resp_write_o,
  input  logic                   stall_en_i
);

  localparam int unsigned BeWidth    = DataWidth / 8;
  localparam int unsigned ByteOffset = $clog2(BeWidth);
  localparam int unsigned IdxWidth   = $clog2(NumWords);
  localparam int unsigned CntWidth   = $clog2(FifoDepth + 1);
  localparam int unsigned PtrWidth   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  logic [15:0]          lfsr_q;
  logic [CntWidth-1:0]  outstanding_q;
  logic [CntWidth-1:0]  occ_eff;
  logic                 accept;
  logic                 pop;
  logic [IdxWidth-1:0]  word_idx;
  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] in_data;

  logic                 push_valid;
  logic [IdWidth-1:0]   push_id;
  logic [DataWidth-1:0] push_data;
  logic                 push_write;

  logic [DataWidth-1:0] fifo_data_q  [FifoDepth];
  logic [IdWidth-1:0]   fifo_id_q    [FifoDepth];
  logic                 fifo_write_q [FifoDepth];
  logic [PtrWidth-1:0]  wr_ptr_q;
  logic [PtrWidth-1:0]  rd_ptr_q;
  logic [CntWidth-1:0]  fifo_cnt_q;
  logic                 fifo_empty;

  // Upper address bits and the byte offset are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^req_addr_i;

  assign word_idx = req_addr_i[ByteOffset +: IdxWidth];
  assign pop      = resp_valid_o && resp_ready_i;
  assign accept   = req_valid_i && req_ready_o;

  // A slot freed by this cycle's pop is reusable in the same cycle, so a
  // full responder can pop and accept simultaneously. pop implies
  // outstanding_q >= 1, so the subtraction never wraps.
  assign occ_eff     = outstanding_q - CntWidth'(pop);
  assign req_ready_o = rst_ni && (occ_eff < CntWidth'(FifoDepth))
                       && !(stall_en_i && lfsr_q[0]);

  // Fibonacci LFSR, taps 16/14/13/11, shifting left with feedback into bit 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Word array: read combinationally in the accept cycle, byte-masked write
  // at the accept edge so the next cycle's read sees the new value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else if (accept && req_wen_i) begin
      for (int b = 0; b < BeWidth; b++) begin
        if (req_be_i[b]) mem_q[word_idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
      end
    end
  end

  assign in_data = req_wen_i ? '0 : mem_q[word_idx];

  // Latency-1 register stages between acceptance and the FIFO push.
  if (Latency == 1) begin : g_no_pipe
    assign push_valid = accept;
    assign push_id    = req_id_i;
    assign push_data  = in_data;
    assign push_write = req_wen_i;
  end else begin : g_pipe
    localparam int unsigned Stages = Latency - 1;
    logic [Stages-1:0]    pv_q;
    logic [Stages-1:0]    pwr_q;
    logic [IdWidth-1:0]   pid_q   [Stages];
    logic [DataWidth-1:0] pdata_q [Stages];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pv_q  <= '0;
        pwr_q <= '0;
        for (int i = 0; i < Stages; i++) begin
          pid_q[i]   <= '0;
          pdata_q[i] <= '0;
        end
      end else begin
        pv_q[0]    <= accept;
        pwr_q[0]   <= req_wen_i;
        pid_q[0]   <= req_id_i;
        pdata_q[0] <= in_data;
        for (int i = 1; i < Stages; i++) begin
          pv_q[i]    <= pv_q[i-1];
          pwr_q[i]   <= pwr_q[i-1];
          pid_q[i]   <= pid_q[i-1];
          pdata_q[i] <= pdata_q[i-1];
        end
      end
    end

    assign push_valid = pv_q[Stages-1];
    assign push_id    = pid_q[Stages-1];
    assign push_data  = pdata_q[Stages-1];
    assign push_write = pwr_q[Stages-1];
  end

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Response FIFO. Occupancy is bounded by the outstanding counter, so a
  // push never finds it full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_valid) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)        rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_valid, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_valid) begin
      fifo_data_q[wr_ptr_q]  <= push_data;
      fifo_id_q[wr_ptr_q]    <= push_id;
      fifo_write_q[wr_ptr_q] <= push_write;
    end
  end

  // Payload is forced to zero when empty so outputs are clean out of reset.
  assign fifo_empty   = (fifo_cnt_q == '0);
  assign resp_valid_o = !fifo_empty;
  assign resp_rdata_o = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
  assign resp_id_o    = fifo_empty ? '0 : fifo_id_q[rd_ptr_q];
  assign resp_write_o = fifo_empty ? 1'b0 : fifo_write_q[rd_ptr_q];

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Testbench for tcdm_bank_responder (default parameters: 256 words, 32-bit
// data, Latency 2, FifoDepth 4, Seed 16'hACE1).
module tb_tcdm_bank_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_wen_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_be_i;
  logic [9:0]  req_id_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic [9:0]  resp_id_o;
  logic        resp_write_o;
  logic        stall_en_i;

  always #5 clk_i = ~clk_i;

  tcdm_bank_responder #(
    .NumWords(256), .DataWidth(32), .AddrWidth(32), .IdWidth(10),
    .Latency(LAT), .FifoDepth(DEPTH), .Seed(SEED)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_wen_i(req_wen_i),
    .req_wdata_i(req_wdata_i), .req_be_i(req_be_i), .req_id_i(req_id_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_id_o(resp_id_o),
    .resp_write_o(resp_write_o), .stall_en_i(stall_en_i)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic        wr;
    logic [9:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  logic        check_exact = 1'b1;
  logic        rand_resp = 1'b0;
  logic [15:0] lfsr_m;
  int          occ_m = 0;
  logic [31:0] ref_mem [256];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference LFSR for the backpressure pattern.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_m <= SEED;
    else         lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    return ref_mem[addr[9:2]];
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) ref_mem[addr[9:2]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Monitor: checks the ready rule and pops/compares responses.
  always @(negedge clk_i) begin : mon
    logic acc;
    logic pop;
    logic exp_rdy;
    exp_t e;
    int   lat;
    if (!rst_ni) begin
      occ_m = 0;
      chk("reset_ready", 32'(req_ready_o), 32'd0);
      chk("reset_valid", 32'(resp_valid_o), 32'd0);
    end else begin
      acc = req_valid_i && req_ready_o;
      pop = resp_valid_o && resp_ready_i;
      exp_rdy = ((occ_m - int'(pop)) < DEPTH) && !(stall_en_i && lfsr_m[0]);
      chk("ready_rule", 32'(req_ready_o), 32'(exp_rdy));
      if (resp_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp_id", 32'(resp_id_o), 32'h0000_ffff);
        end else if (resp_ready_i) begin
          e = exp_q.pop_front();
          chk("resp_id", 32'(resp_id_o), 32'(e.id));
          chk("resp_rdata", resp_rdata_o, e.data);
          chk("resp_write", 32'(resp_write_o), 32'(e.wr));
          lat = cyc - int'(e.cyc);
          if (check_exact) chk("resp_latency", 32'(lat), 32'(LAT));
          else             chk("resp_latency_min", 32'(lat >= LAT), 32'd1);
        end
      end
      occ_m = occ_m + int'(acc) - int'(pop);
    end
  end

  // Random response backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      if (rand_resp) resp_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [9:0] id,
                      input logic [31:0] exp_rdata, output int waits);
    bit ok;
    req_valid_i = 1'b1;
    req_wen_i   = wen;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_be_i    = be;
    req_id_i    = id;
    ok    = 0;
    waits = 0;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        exp_q.push_back('{cyc: 32'(cyc), wr: wen, id: id, data: (wen ? 32'd0 : exp_rdata)});
        ok = 1;
        @(posedge clk_i); #1;
        break;
      end
      waits++;
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) begin
      @(posedge clk_i); #1;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [9:0]  id;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int waits;
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic [3:0]  be;

    tbl[0]  = '{1'b0, 32'h0000_0008, 32'h0,          4'hF, 10'd5,    32'h0000_0000};
    tbl[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  4'hF, 10'd6,    32'h0000_0000};
    tbl[2]  = '{1'b1, 32'h0000_0010, 32'h0000_AA00,  4'h2, 10'd7,    32'h0000_0000};
    tbl[3]  = '{1'b0, 32'h0000_0010, 32'h0,          4'hF, 10'd8,    32'hDEAD_AAEF};
    tbl[4]  = '{1'b1, 32'h0000_0014, 32'h1234_5678,  4'h0, 10'd9,    32'h0000_0000};
    tbl[5]  = '{1'b0, 32'h0000_0014, 32'h0,          4'hF, 10'd10,   32'h0000_0000};
    tbl[6]  = '{1'b1, 32'h0000_0414, 32'hCAFE_F00D,  4'h9, 10'd11,   32'h0000_0000};
    tbl[7]  = '{1'b0, 32'h0000_0014, 32'h0,          4'hF, 10'd12,   32'hCA00_000D};
    tbl[8]  = '{1'b0, 32'hABCD_0410, 32'h0,          4'hF, 10'd13,   32'hDEAD_AAEF};
    tbl[9]  = '{1'b1, 32'h0000_03FC, 32'h1122_3344,  4'hF, 10'd14,   32'h0000_0000};
    tbl[10] = '{1'b0, 32'h0000_03FC, 32'h0,          4'hF, 10'd15,   32'h1122_3344};
    tbl[11] = '{1'b0, 32'h0000_0000, 32'h0,          4'hF, 10'd1023, 32'h0000_0000};
    tbl[12] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF,  4'h4, 10'd0,    32'h0000_0000};
    tbl[13] = '{1'b0, 32'h0000_0000, 32'h0,          4'hF, 10'd16,   32'h00FF_0000};
    tbl[14] = '{1'b0, 32'h0000_0400, 32'h0,          4'hF, 10'd17,   32'h00FF_0000};

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_addr_i = '0; req_wen_i = 1'b0; req_wdata_i = '0;
    req_be_i = '0; req_id_i = '0; resp_ready_i = 1'b0; stall_en_i = 1'b0;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_resp_rdata", resp_rdata_o, 32'd0);
    chk("rst_resp_id", 32'(resp_id_o), 32'd0);
    chk("rst_resp_write", 32'(resp_write_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_release", 32'(req_ready_o), 32'd1);
    @(posedge clk_i); #1;

    // Table-driven vectors, back to back, responses always accepted
    resp_ready_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].id, tbl[i].rdata, waits);
      chk("tbl_accept_wait", 32'(waits), 32'd0);
      if (tbl[i].wen) ref_write(tbl[i].addr, tbl[i].wdata, tbl[i].be);
    end
    drain(20);

    // Backpressure: fill to FifoDepth with responses blocked
    check_exact = 1'b0;
    resp_ready_i = 1'b0;
    for (int id = 1; id <= 4; id++) begin
      a = 32'h40 + 32'(id) * 4;
      send(1'b0, a, 32'h0, 4'hF, 10'(id), ref_read(a), waits);
      chk("bp_accept_wait", 32'(waits), 32'd0);
    end
    req_valid_i = 1'b1; req_wen_i = 1'b0; req_addr_i = 32'h54; req_id_i = 10'd5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("bp_full_ready", 32'(req_ready_o), 32'd0);
      chk("bp_hold_valid", 32'(resp_valid_o), 32'd1);
      chk("bp_hold_id", 32'(resp_id_o), 32'd1);
      chk("bp_hold_write", 32'(resp_write_o), 32'd0);
      @(posedge clk_i); #1;
    end
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_pop_frees_slot", 32'(req_ready_o), 32'd1);
    if (req_ready_o) exp_q.push_back('{cyc: 32'(cyc), wr: 1'b0, id: 10'd5, data: ref_read(32'h54)});
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    req_addr_i = 32'h58; req_id_i = 10'd6;
    @(negedge clk_i);
    chk("bp_full_again", 32'(req_ready_o), 32'd0);
    chk("bp_next_head", 32'(resp_id_o), 32'd2);
    @(posedge clk_i); #1;
    resp_ready_i = 1'b1;
    send(1'b0, 32'h58, 32'h0, 4'hF, 10'd6, ref_read(32'h58), waits);
    drain(20);
    check_exact = 1'b1;

    // Streaming: 100 reads on consecutive cycles
    for (int i = 0; i < 100; i++) begin
      a = 32'($urandom_range(0, 31)) << 2;
      send(1'b0, a, 32'h0, 4'hF, 10'(i), ref_read(a), waits);
      chk("stream_no_bubble", 32'(waits), 32'd0);
    end
    drain(20);

    // Random stall with random response backpressure, mixed reads/writes
    check_exact = 1'b0;
    stall_en_i = 1'b1;
    rand_resp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      w  = 1'($urandom_range(0, 1));
      a  = {20'($urandom), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 3) * 4)};
      a[9:6] = 4'd0;
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      send(w, a, d, be, 10'(i + 300), ref_read(a), waits);
      if (w) ref_write(a, d, be);
    end
    drain(500);
    rand_resp = 1'b0;
    stall_en_i = 1'b0;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b1;
    check_exact = 1'b1;

    // Reset mid-flight
    resp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 32'h10, 32'h0, 4'hF, 10'(100 + i), ref_read(32'h10), waits);
    end
    #3;
    chk("pre_reset_valid", 32'(resp_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("async_reset_valid", 32'(resp_valid_o), 32'd0);
    chk("async_reset_ready", 32'(req_ready_o), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    resp_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      chk("no_stale_resp", 32'(resp_valid_o), 32'd0);
    end
    @(posedge clk_i); #1;
    send(1'b0, 32'h10, 32'h0, 4'hF, 10'd200, 32'd0, waits);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tcdm_bank_responder.md
# tcdm_bank_responder

Target-side model of the TCDM request/response channel. It accepts id-tagged read/write requests from a core-side initiator such as the traffic generator or the address demux outputs, and services them from a small local word array. It returns id-tagged responses in order after a fixed latency, and can apply pseudo-random backpressure. It is used in testbenches and standalone bring-up as the far end of one TCDM port.

## Interface
Parameters:
- NumWords, 256: words in the local array; power of two.
- DataWidth, 32: data width in bits.
- AddrWidth, 32: byte-address width.
- IdWidth, 10: request/response id width.
- Latency, 2: cycles from acceptance to earliest response; must be ≥1.
- FifoDepth, 4: maximum outstanding requests, counting the pipeline and the FIFO; must be ≥ Latency.
- Seed, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- req_valid_i, in, 1: request valid.
- req_ready_o, out, 1: request ready.
- req_addr_i, in, AddrWidth: byte address.
- req_wen_i, in, 1: 1 = write.
- req_wdata_i, in, DataWidth: write data.
- req_be_i, in, DataWidth/8: byte enables.
- req_id_i, in, IdWidth: request id.
- resp_valid_o, out, 1: response valid.
- resp_ready_i, in, 1: response ready.
- resp_rdata_o, out, DataWidth: read data; 0 for write responses.
- resp_id_o, out, IdWidth: id echoed from the request.
- resp_write_o, out, 1: 1 if the response belongs to a write.
- stall_en_i, in, 1: enables pseudo-random request backpressure.

## Operation
- **Acceptance.** A request is accepted in a cycle where req_valid_i && req_ready_o at the rising edge.
- **Ready rule.** req_ready_o = (outstanding < FifoDepth) && !(stall_en_i && lfsr[0]).
  - It must not depend on req_valid_i.
  - It is 0 while rst_ni is low.
- **Outstanding counter.** Width $clog2(FifoDepth+1).
  - +1 on accept, −1 on response pop (resp_valid_o && resp_ready_i).
  - Unchanged when both happen in the same cycle.
  - Never exceeds FifoDepth; the FIFO can never overflow.
- **Word index.** req_addr_i[ByteOffset +: $clog2(NumWords)], with ByteOffset = $clog2(DataWidth/8). Upper address bits are ignored, so addresses wrap modulo the array size.
- **Read.** The array is read in the accept cycle. {id, data, write=0} enters the pipeline.
- **Write.** At the accept edge, each byte with a set req_be_i bit is updated. {id, data=0, write=1} enters the pipeline.
  - A read accepted in the next cycle sees the new value.
  - be = 0 still produces a response.
- **Pipeline and FIFO.**
  - Pipeline: Latency−1 register stages (valid, id, data, write).
  - FIFO: depth FifoDepth. The last stage (or the accept itself, when Latency = 1) pushes into it.
  - FIFO head drives the response outputs combinationally.
  - resp_valid_o = FIFO not empty.
- **Ordering.** Responses return strictly in acceptance order.
- **Response hold.** While resp_valid_o && !resp_ready_i, resp_rdata_o, resp_id_o and resp_write_o are held stable.
- **LFSR.**
  - 16-bit Fibonacci LFSR, taps 16, 14, 13, 11 (feedback into bit 0, shift left).
  - Advances every cycle regardless of stall_en_i.
  - Reset value is Seed.
- **Reset.** Reset clears the counter, pipeline and FIFO, reloads the LFSR, and zeroes the array.

## Timing
- **Latency.** A request accepted in cycle c gives resp_valid_o high at the earliest in cycle c+Latency.
  - The response is later only if older responses are still unpopped.
- **Throughput.** One request per cycle when resp_ready_i is held high.
- **Freeing a slot.** A pop in cycle c raises req_ready_o in the same cycle c. The counter decrement is combinationally visible in the ready rule, so simultaneous pop and accept at full occupancy is allowed.
- **Reset values.** req_ready_o = 0, resp_valid_o = 0, resp_rdata_o = 0, resp_id_o = 0, resp_write_o = 0.
- **Reset mid-operation.** All in-flight requests are dropped. resp_valid_o falls asynchronously when rst_ni falls, and no response is emitted after release.
- **After reset release.** req_ready_o = 1 in the first cycle, provided stall_en_i = 0.

## Test plan
- **Single read.** Latency = 2. Read of 0x8 with id 5 accepted in cycle c → resp_valid_o in cycle c+2, rdata 0, id 5, write 0.
- **Partial write.**
  - Write 0xDEADBEEF to 0x10 with be 4'b1111.
  - Then write 0x0000AA00 to 0x10 with be 4'b0010.
  - Then read 0x10 → rdata 0xDEADAAEF. Both write responses have write = 1 and rdata 0.
- **Backpressure full.**
  - FifoDepth = 4, resp_ready_i = 0, back-to-back reads with ids 1..6 → exactly ids 1–4 accepted, then req_ready_o = 0.
  - The response stays stable at id 1.
  - Pulse resp_ready_i for one cycle → id 5 is accepted in that same cycle.
- **Streaming.** resp_ready_i = 1, 100 reads with ids 0..99 on consecutive cycles → all accepted without a bubble. Responses come in id order, one per cycle, starting at cycle c0+Latency.
- **Random stall.**
  - stall_en_i = 1, Seed = 16'hACE1 → each cycle, req_ready_o equals !lfsr[0] of a reference LFSR model (given occupancy below FifoDepth).
  - 200 requests complete with no loss or reordering.
- **Reset mid-flight.** Three requests in flight, then rst_ni pulsed low → resp_valid_o drops immediately and no stale responses follow. A read of a previously written address returns 0.
